// File: rtl/fir_out_stage.sv
// FIR output stage: buffers filter results in a FIFO and emits them as 8-bit valid/ready beats.
// Define FIR_OUT_ROUND_EN to round half up (instead of truncating) in scaled mode.
module fir_out_stage #(
  parameter int unsigned Y_N_SIZE   = 11,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [Y_N_SIZE-1:0] y_in,
  input  logic                       y_valid,
  input  logic                       mode,
  input  logic                       o_ready,
  output logic [7:0]                 o_data,
  output logic                       o_valid,
  output logic                       o_last,
  output logic                       fifo_full,
  output logic                       overflow,
  output logic                       sat_flag
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FIFO_DEPTH);
  localparam logic signed [Y_N_SIZE:0] SatMax = (Y_N_SIZE+1)'(127);
  localparam logic signed [Y_N_SIZE:0] SatMin = (Y_N_SIZE+1)'(-128);

  typedef enum logic [1:0] {StIdle, StSend, StSendHi} state_e;

  state_e                     r_state, w_state_d;
  logic signed [Y_N_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]              r_count, w_count_d, w_unread;
  logic [7:0]                 r_data, w_data_d, r_hi_byte, w_scaled;
  logic                       r_valid, w_valid_d, r_last, w_last_d, r_mode;
  logic                       r_full, r_overflow, r_sat;
  logic                       w_hs, w_load, w_free, w_push, w_have_next, w_clip;
  logic signed [Y_N_SIZE-1:0] w_head;
  logic signed [Y_N_SIZE:0]   w_ext, w_sum, w_t;

  // The sample being emitted keeps its slot until its final beat is accepted,
  // so the occupancy count includes it.
  assign w_head      = r_mem[r_rd_ptr];
  assign w_unread    = r_count - (PtrW+1)'(r_state != StIdle);
  assign w_have_next = (w_unread != '0);
  assign w_hs        = r_valid & o_ready;
  assign w_push      = y_valid & ((r_count != FullCnt) | w_free);

  assign w_ext = {w_head[Y_N_SIZE-1], w_head};
`ifdef FIR_OUT_ROUND_EN
  localparam logic signed [Y_N_SIZE:0] RoundAdd = (Y_N_SIZE+1)'(1) << (SHIFT - 1);
  assign w_sum = w_ext + RoundAdd;
`else
  assign w_sum = w_ext;
`endif
  assign w_t = w_sum >>> SHIFT;

  always_comb begin
    w_clip   = 1'b0;
    w_scaled = 8'(w_t);
    if (w_t > SatMax) begin
      w_scaled = 8'h7f;
      w_clip   = 1'b1;
    end else if (w_t < SatMin) begin
      w_scaled = 8'h80;
      w_clip   = 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_free    = 1'b0;
    w_data_d  = r_data;
    w_last_d  = r_last;
    w_valid_d = r_valid;
    unique case (r_state)
      StIdle: begin
        if (w_have_next) begin
          w_load    = 1'b1;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (w_hs) begin
          if (r_mode) begin
            w_data_d  = r_hi_byte;
            w_last_d  = 1'b1;
            w_state_d = StSendHi;
          end else begin
            w_free = 1'b1;
            if (w_have_next) begin
              w_load = 1'b1;
            end else begin
              w_state_d = StIdle;
              w_valid_d = 1'b0;
            end
          end
        end
      end
      StSendHi: begin
        if (w_hs) begin
          w_free = 1'b1;
          if (w_have_next) begin
            w_load    = 1'b1;
            w_state_d = StSend;
          end else begin
            w_state_d = StIdle;
            w_valid_d = 1'b0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_load) begin
      w_valid_d = 1'b1;
      w_data_d  = mode ? w_head[7:0] : w_scaled;
      w_last_d  = ~mode;
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_free) begin
      w_count_d = r_count + (PtrW+1)'(1);
    end else if (!w_push && w_free) begin
      w_count_d = r_count - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_mode     <= 1'b0;
      r_hi_byte  <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_full     <= (w_count_d == FullCnt);
      r_data     <= w_data_d;
      r_valid    <= w_valid_d;
      r_last     <= w_last_d;
      r_overflow <= r_overflow | (y_valid & ~w_push);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + PtrW'(1);
        r_mode    <= mode;
        r_hi_byte <= 8'(w_head >>> 8);
        r_sat     <= r_sat | (w_clip & ~mode);
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_last    = r_last;
  assign fifo_full = r_full;
  assign overflow  = r_overflow;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench for fir_out_stage: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_fir_out_stage;
  localparam int Y  = 11;
  localparam int SH = 2;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [Y-1:0] y_in = '0;
  logic         y_valid = 1'b0;
  logic         mode = 1'b0;
  logic         o_ready = 1'b0;
  logic [7:0]   o_data;
  logic         o_valid, o_last, fifo_full, overflow, sat_flag;

  fir_out_stage #(.Y_N_SIZE(Y), .SHIFT(SH), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .mode(mode),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
    .fifo_full(fifo_full), .overflow(overflow), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int n_done   = 0;
  int got_data[$];
  int got_last[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake happens at the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (!reset && o_valid && o_ready) begin
      got_data.push_back(int'(o_data));
      got_last.push_back(int'(o_last));
      got_cyc.push_back(cyc);
      if (o_last) n_done <= n_done + 1;
    end
  end

  function automatic int model_scaled(input int v);
    int t;
`ifdef FIR_OUT_ROUND_EN
    t = (v + (1 << (SH - 1))) >>> SH;
`else
    t = v >>> SH;
`endif
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t & 255;
  endfunction

  function automatic int model_lo(input int v);
    return v & 255;
  endfunction

  function automatic int model_hi(input int v);
    return (v >>> 8) & 255;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    y_in    = v[Y-1:0];
    y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int i = 0; i < 400 && got_data.size() < n; i++) tick();
    ok = (got_data.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fails++; $display("FAIL reset_o_data got %h want 00", o_data); end
    n_checks++; if (o_last !== 1'b0) begin n_fails++; $display("FAIL reset_o_last got %b want 0", o_last); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fails++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
  endtask

  task automatic test_latency();
    int e;
    mode = 1'b0; o_ready = 1'b1; clear_got();
    e = model_scaled(100);
    push(100);
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("FAIL lat_early_valid got %b want 0", o_valid); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fails++; $display("FAIL lat_valid got %b want 1", o_valid); end
    n_checks++; if (o_data !== 8'(e)) begin n_fails++; $display("FAIL lat_data got %0d want %0d", o_data, e); end
    n_checks++; if (o_last !== 1'b1) begin n_fails++; $display("FAIL lat_last got %b want 1", o_last); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("FAIL lat_drop got %b want 0", o_valid); end
    n_checks++; if (got_data.size() != 1) begin n_fails++; $display("FAIL lat_count got %0d want 1", got_data.size()); end
  endtask

  task automatic test_saturation();
    bit ok;
    mode = 1'b0; o_ready = 1'b1; clear_got();
    push(1000);
    push(-1000);
    n_checks++; if (sat_flag !== 1'b1) begin n_fails++; $display("FAIL sat_flag_set got %b want 1", sat_flag); end
    wait_beats(2, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL sat_timeout got %0d beats want 2", got_data.size()); end
    if (ok) begin
      n_checks++; if (got_data[0] != model_scaled(1000)) begin n_fails++; $display("FAIL sat_pos got %h want %h", got_data[0], model_scaled(1000)); end
      n_checks++; if (got_data[1] != model_scaled(-1000)) begin n_fails++; $display("FAIL sat_neg got %h want %h", got_data[1], model_scaled(-1000)); end
      n_checks++; if (got_last[0] != 1 || got_last[1] != 1) begin n_fails++; $display("FAIL sat_last got %0d%0d want 11", got_last[0], got_last[1]); end
    end
    tick();
    n_checks++; if (sat_flag !== 1'b1) begin n_fails++; $display("FAIL sat_sticky got %b want 1", sat_flag); end
  endtask

  task automatic test_mode1_split();
    bit ok;
    mode = 1'b1; o_ready = 1'b1; clear_got();
    push(-300);
    tick();
    mode = 1'b0;
    wait_beats(2, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL split_timeout got %0d beats want 2", got_data.size()); end
    if (ok) begin
      n_checks++; if (got_data[0] != model_lo(-300) || got_last[0] != 0) begin n_fails++; $display("FAIL split_lo got %h/%0d want %h/0", got_data[0], got_last[0], model_lo(-300)); end
      n_checks++; if (got_data[1] != model_hi(-300) || got_last[1] != 1) begin n_fails++; $display("FAIL split_hi got %h/%0d want %h/1", got_data[1], got_last[1], model_hi(-300)); end
      n_checks++; if (got_cyc[1] != got_cyc[0] + 1) begin n_fails++; $display("FAIL split_gap got %0d want %0d", got_cyc[1], got_cyc[0] + 1); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int exp_q[$];
    mode = 1'b1; o_ready = 1'b0; clear_got();
    for (int s = 1; s <= 4; s++) begin
      push(s);
      exp_q.push_back(model_lo(s));
      exp_q.push_back(model_hi(s));
    end
    n_checks++; if (fifo_full !== 1'b1) begin n_fails++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("FAIL ovf_early got %b want 0", overflow); end
    push(5);
    n_checks++; if (overflow !== 1'b1) begin n_fails++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_checks++; if (o_valid !== 1'b1 || o_data !== 8'(model_lo(1)) || o_last !== 1'b0) begin
      n_fails++; $display("FAIL ovf_hold got %b/%h/%b want 1/%h/0", o_valid, o_data, o_last, model_lo(1));
    end
    o_ready = 1'b1;
    wait_beats(8, ok);
    repeat (6) tick();
    n_checks++; if (got_data.size() != 8) begin n_fails++; $display("FAIL ovf_count got %0d want 8", got_data.size()); end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (got_data[i] != exp_q[i] || got_last[i] != (i % 2)) begin
          n_fails++; $display("FAIL ovf_beat%0d got %h/%0d want %h/%0d", i, got_data[i], got_last[i], exp_q[i], i % 2);
        end
      end
      n_checks++; if (got_cyc[7] != got_cyc[0] + 7) begin n_fails++; $display("FAIL ovf_bubbles got span %0d want 7", got_cyc[7] - got_cyc[0]); end
    end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL ovf_drained got %b want 0", fifo_full); end
  endtask

  task automatic test_rounding();
    bit ok;
    mode = 1'b0; o_ready = 1'b1; clear_got();
    push(6);
    push(-6);
    wait_beats(2, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL round_timeout got %0d beats want 2", got_data.size()); end
    if (ok) begin
      n_checks++; if (got_data[0] != model_scaled(6)) begin n_fails++; $display("FAIL round_pos got %h want %h", got_data[0], model_scaled(6)); end
      n_checks++; if (got_data[1] != model_scaled(-6)) begin n_fails++; $display("FAIL round_neg got %h want %h", got_data[1], model_scaled(-6)); end
    end
  endtask

  task automatic test_random(input bit m);
    bit ok;
    int exp_d[$];
    int exp_l[$];
    int pushed, v;
    mode = m; clear_got();
    pushed = 0;
    n_done = 0;
    for (int c = 0; c < 300; c++) begin
      o_ready = ($urandom_range(0, 3) != 0);
      if (pushed - n_done < D && $urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, (1 << Y) - 1);
        if (v >= (1 << (Y - 1))) v -= (1 << Y);
        y_in = v[Y-1:0];
        y_valid = 1'b1;
        pushed++;
        if (m) begin
          exp_d.push_back(model_lo(v)); exp_l.push_back(0);
          exp_d.push_back(model_hi(v)); exp_l.push_back(1);
        end else begin
          exp_d.push_back(model_scaled(v)); exp_l.push_back(1);
        end
      end else begin
        y_valid = 1'b0;
      end
      tick();
    end
    y_valid = 1'b0;
    o_ready = 1'b1;
    wait_beats(exp_d.size(), ok);
    repeat (4) tick();
    n_checks++; if (got_data.size() != exp_d.size()) begin n_fails++; $display("FAIL rand%0d_count got %0d want %0d", m, got_data.size(), exp_d.size()); end
    if (ok) begin
      for (int i = 0; i < exp_d.size(); i++) begin
        n_checks++; if (got_data[i] != exp_d[i] || got_last[i] != exp_l[i]) begin
          n_fails++; $display("FAIL rand%0d_beat%0d got %h/%0d want %h/%0d", m, i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midway();
    mode = 1'b0; o_ready = 1'b0; clear_got();
    push(8);
    push(12);
    push(16);
    n_checks++; if (o_valid !== 1'b1) begin n_fails++; $display("FAIL mid_pending got %b want 1", o_valid); end
    reset = 1'b1;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("FAIL mid_o_valid got %b want 0", o_valid); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL mid_fifo_full got %b want 0", fifo_full); end
    n_checks++; if (overflow !== 1'b0 || sat_flag !== 1'b0) begin n_fails++; $display("FAIL mid_flags got %b%b want 00", overflow, sat_flag); end
    n_checks++; if (o_data !== 8'h00 || o_last !== 1'b0) begin n_fails++; $display("FAIL mid_data got %h/%b want 00/0", o_data, o_last); end
    reset = 1'b0;
    o_ready = 1'b1;
    clear_got();
    repeat (10) tick();
    n_checks++; if (got_data.size() != 0) begin n_fails++; $display("FAIL mid_stale got %0d beats want 0", got_data.size()); end
    push(40);
    repeat (6) tick();
    n_checks++; if (got_data.size() != 1) begin n_fails++; $display("FAIL mid_new_count got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_checks++; if (got_data[0] != model_scaled(40) || got_last[0] != 1) begin
        n_fails++; $display("FAIL mid_new_beat got %h/%0d want %h/1", got_data[0], got_last[0], model_scaled(40));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_mode1_split();
    test_overflow();
    test_rounding();
    test_random(1'b0);
    test_random(1'b1);
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
